// File: rtl/tiny_dnn_pkg.sv
// Shared types for the MNIST accelerator layer sequencer: descriptor layout,
// sequencer states and descriptor word indices.
package tiny_dnn_pkg;

  localparam int W_GEOM_I = 0;
  localparam int W_GEOM_O = 1;
  localparam int W_KERN   = 2;
  localparam int W_CNT    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BIAS,
    S_GAP,
    S_WGT,
    S_RUN
  } seq_state_t;

  typedef struct packed {
    logic        backprop;
    logic [3:0]  id;
    logic [9:0]  is;
    logic [4:0]  ih;
    logic [4:0]  iw;
    logic [3:0]  od;
    logic [9:0]  os;
    logic [4:0]  oh;
    logic [4:0]  ow;
    logic [7:0]  fs;
    logic [4:0]  ks;
    logic [2:0]  kh;
    logic [2:0]  kw;
    logic [13:0] nw;
    logic [11:0] nsamp;
  } layer_desc_t;

  // Unused MSBs of each word are dropped here.
  function automatic layer_desc_t unpack_desc(input logic [3:0][31:0] w);
    layer_desc_t d;
    d.backprop = w[W_GEOM_I][0];
    d.id       = w[W_GEOM_I][4:1];
    d.is       = w[W_GEOM_I][14:5];
    d.ih       = w[W_GEOM_I][19:15];
    d.iw       = w[W_GEOM_I][24:20];
    d.od       = w[W_GEOM_O][3:0];
    d.os       = w[W_GEOM_O][13:4];
    d.oh       = w[W_GEOM_O][18:14];
    d.ow       = w[W_GEOM_O][23:19];
    d.fs       = w[W_KERN][7:0];
    d.ks       = w[W_KERN][12:8];
    d.kh       = w[W_KERN][15:13];
    d.kw       = w[W_KERN][18:16];
    d.nw       = w[W_CNT][13:0];
    d.nsamp    = w[W_CNT][25:14];
    return d;
  endfunction

endpackage

// File: rtl/desc_table.sv
// Per-layer descriptor register file: four 32-bit words per layer, synchronous
// write, combinational read of a whole layer.
module desc_table #(
  parameter  int NL = 8,
  localparam int LW = $clog2(NL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [LW+1:0]    waddr,
  input  logic [31:0]      wdata,
  input  logic [LW-1:0]    rlayer,
  output logic [3:0][31:0] rdata
);

  logic [3:0][31:0] r_mem [NL];

  // NOTE: the table is cleared by reset because an unprogrammed layer must read
  // as all-zero geometry and counts; a plain RAM would come up undefined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr[LW+1:2]][waddr[1:0]] <= wdata;
    end
  end

  assign rdata = r_mem[rlayer];

endmodule

// File: rtl/layer_seq.sv
// Layer sequencer: walks layers 0..nlayers through bias-load, weight-load and
// run phases, inserting one all-modes-low cycle between phases.
module layer_seq
  import tiny_dnn_pkg::*;
#(
  parameter  int NL = 8,
  localparam int LW = $clog2(NL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [LW+1:0] cfg_addr,
  input  logic [31:0]   cfg_wdata,
  input  logic          start,
  input  logic [LW-1:0] nlayers,
  input  logic          src_valid,
  input  logic          src_ready,
  input  logic          smp_done,
  output logic          bwrite,
  output logic          wwrite,
  output logic          run,
  output logic          backprop,
  output logic [3:0]    id,
  output logic [9:0]    is,
  output logic [4:0]    ih,
  output logic [4:0]    iw,
  output logic [3:0]    od,
  output logic [9:0]    os,
  output logic [4:0]    oh,
  output logic [4:0]    ow,
  output logic [7:0]    fs,
  output logic [4:0]    ks,
  output logic [2:0]    kh,
  output logic [2:0]    kw,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] cur_layer
);

  seq_state_t       r_state, w_next_state;
  seq_state_t       r_gap_target, w_next_target;
  logic [LW-1:0]    r_cur_layer, w_next_layer, r_nlayers;
  logic [13:0]      r_beat;
  logic [11:0]      r_samp;
  layer_desc_t      r_desc, w_rd_desc;
  logic [3:0][31:0] w_rd_words;
  logic             w_beat, w_bias_last, w_wgt_last, w_run_last, w_done;
  logic             r_bwrite, r_wwrite, r_run, r_busy, r_done;

  desc_table #(.NL(NL)) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we & ~r_busy),
    .waddr  (cfg_addr),
    .wdata  (cfg_wdata),
    .rlayer (r_cur_layer),
    .rdata  (w_rd_words)
  );

  assign w_rd_desc   = unpack_desc(w_rd_words);
  assign w_beat      = src_valid & src_ready;
  // Counters hold the number of events already seen, so "== limit" marks the final one.
  assign w_bias_last = (r_beat == {10'd0, r_desc.od});
  assign w_wgt_last  = (r_beat == r_desc.nw);
  assign w_run_last  = (r_samp == r_desc.nsamp);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state  = r_state;
    w_next_target = r_gap_target;
    w_next_layer  = r_cur_layer;
    w_done        = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_next_state = S_LOAD;
        w_next_layer = '0;
      end
      S_LOAD: if (w_rd_desc.backprop) begin
        w_next_state  = S_GAP;
        w_next_target = S_WGT;
      end else begin
        w_next_state = S_BIAS;
      end
      S_BIAS: if (w_beat && w_bias_last) begin
        w_next_state  = S_GAP;
        w_next_target = S_WGT;
      end
      S_GAP: w_next_state = r_gap_target;
      S_WGT: if (w_beat && w_wgt_last) begin
        w_next_state  = S_GAP;
        w_next_target = S_RUN;
      end
      S_RUN: if (smp_done && w_run_last) begin
        if (r_cur_layer == r_nlayers) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_LOAD;
          w_next_layer = r_cur_layer + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gap_target <= S_IDLE;
      r_cur_layer  <= '0;
      r_nlayers    <= '0;
      r_desc       <= '0;
      r_bwrite     <= 1'b0;
      r_wwrite     <= 1'b0;
      r_run        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_gap_target <= w_next_target;
      r_cur_layer  <= w_next_layer;
      if (r_state == S_IDLE && start) r_nlayers <= nlayers;
      if (r_state == S_LOAD) r_desc <= w_rd_desc;
      r_bwrite     <= (w_next_state == S_BIAS);
      r_wwrite     <= (w_next_state == S_WGT);
      r_run        <= (w_next_state == S_RUN);
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= w_done;
    end
  end

  // Event counters restart on every phase change; events outside their phase are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
      r_samp <= '0;
    end else if (w_next_state != r_state) begin
      r_beat <= '0;
      r_samp <= '0;
    end else begin
      if (w_beat && (r_state == S_BIAS || r_state == S_WGT)) r_beat <= r_beat + 1'b1;
      if (smp_done && r_state == S_RUN) r_samp <= r_samp + 1'b1;
    end
  end

  assign bwrite    = r_bwrite;
  assign wwrite    = r_wwrite;
  assign run       = r_run;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cur_layer = r_cur_layer;
  assign backprop  = r_desc.backprop;
  assign id        = r_desc.id;
  assign is        = r_desc.is;
  assign ih        = r_desc.ih;
  assign iw        = r_desc.iw;
  assign od        = r_desc.od;
  assign os        = r_desc.os;
  assign oh        = r_desc.oh;
  assign ow        = r_desc.ow;
  assign fs        = r_desc.fs;
  assign ks        = r_desc.ks;
  assign kh        = r_desc.kh;
  assign kw        = r_desc.kw;

endmodule

// File: tb/tb_layer_seq.sv
// Self-checking bench for layer_seq: the observed mode trace is split into
// phase segments and compared with a phase list derived from the descriptors.
module tb_layer_seq;

  localparam int NL     = 8;
  localparam int LW     = 3;
  localparam int BUDGET = 40000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [LW+1:0] cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          start;
  logic [LW-1:0] nlayers;
  logic          src_valid, src_ready, smp_done;
  logic          bwrite, wwrite, run, backprop, busy, done;
  logic [3:0]    id, od;
  logic [9:0]    is, os;
  logic [4:0]    ih, iw, oh, ow, ks;
  logic [7:0]    fs;
  logic [2:0]    kh, kw;
  logic [LW-1:0] cur_layer;

  layer_seq #(.NL(NL)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .nlayers(nlayers), .src_valid(src_valid), .src_ready(src_ready),
    .smp_done(smp_done), .bwrite(bwrite), .wwrite(wwrite), .run(run), .backprop(backprop),
    .id(id), .is(is), .ih(ih), .iw(iw), .od(od), .os(os), .oh(oh), .ow(ow),
    .fs(fs), .ks(ks), .kh(kh), .kw(kw), .busy(busy), .done(done), .cur_layer(cur_layer)
  );

  always #5 clk = ~clk;

  // mode: 0 none, 1 bias, 2 weight, 3 run, 4 several at once
  typedef struct {
    int          mode;
    int          len;
    int          ev;
    bit          last_ev;
    logic [67:0] geom;
    bit          geom_stable;
    int          layer;
    bit          layer_stable;
  } seg_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] tbl [NL][4];
  seg_t        segq[$];
  seg_t        expq[$];
  bit          first_busy, done_busy, timed_out, extra_busy;
  int          done_cnt;

  function automatic seg_t mk_seg(input int mode, input int len, input int ev,
                                  input logic [67:0] g, input int layer);
    seg_t s;
    s.mode = mode; s.len = len; s.ev = ev; s.last_ev = 1'b0; s.geom = g;
    s.geom_stable = 1'b1; s.layer = layer; s.layer_stable = 1'b1;
    return s;
  endfunction

  function automatic logic [67:0] obs_geom();
    return {backprop, id, is, ih, iw, od, os, oh, ow, fs, ks, kh, kw};
  endfunction

  function automatic logic [67:0] exp_geom(input int l);
    logic [31:0] w0, w1, w2;
    w0 = tbl[l][0]; w1 = tbl[l][1]; w2 = tbl[l][2];
    return {w0[0], w0[4:1], w0[14:5], w0[19:15], w0[24:20],
            w1[3:0], w1[13:4], w1[18:14], w1[23:19],
            w2[7:0], w2[12:8], w2[15:13], w2[18:16]};
  endfunction

  function automatic int mode_code();
    int c;
    c = int'(bwrite) + int'(wwrite) + int'(run);
    if (c > 1) return 4;
    if (bwrite) return 1;
    if (wwrite) return 2;
    if (run) return 3;
    return 0;
  endfunction

  task automatic cfg_write(input int l, input int wi, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = {l[LW-1:0], wi[1:0]}; cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[l][wi] = d;
  endtask

  task automatic load_desc(input int l, input bit bp, input int od_v, input int nw_v, input int ns_v);
    logic [31:0] w [4];
    w[0] = $urandom; w[0][0] = bp;
    w[1] = $urandom; w[1][3:0] = od_v[3:0];
    w[2] = $urandom;
    w[3] = $urandom; w[3][13:0] = nw_v[13:0]; w[3][25:14] = ns_v[11:0];
    for (int wi = 0; wi < 4; wi++) cfg_write(l, wi, w[wi]);
  endtask

  // Phase list implied by the descriptors of layers 0..nl.
  task automatic build_expect(input int nl);
    bit bp;
    expq.delete();
    for (int l = 0; l <= nl; l++) begin
      bp = tbl[l][0][0];
      expq.push_back(mk_seg(0, bp ? 2 : 1, 0, '0, l));
      if (!bp) begin
        expq.push_back(mk_seg(1, 0, int'(tbl[l][1][3:0]) + 1, exp_geom(l), l));
        expq.push_back(mk_seg(0, 1, 0, '0, l));
      end
      expq.push_back(mk_seg(2, 0, int'(tbl[l][3][13:0]) + 1, exp_geom(l), l));
      expq.push_back(mk_seg(0, 1, 0, '0, l));
      expq.push_back(mk_seg(3, 0, int'(tbl[l][3][25:14]) + 1, exp_geom(l), l));
    end
  endtask

  // Pulses start, drives random traffic and records the mode trace until done.
  task automatic run_seq(input int nl, input int pct, input bit stray, input bit meddle);
    seg_t        cur;
    bit          have, bt;
    int          cyc, m;
    logic [67:0] g;
    segq.delete(); have = 1'b0; cyc = 0; extra_busy = 1'b0;
    start = 1'b1; nlayers = nl[LW-1:0];
    @(negedge clk);
    start = 1'b0;
    first_busy = busy;
    while (done !== 1'b1 && cyc < BUDGET) begin
      m = mode_code();
      src_valid = ($urandom_range(99) < pct);
      src_ready = ($urandom_range(99) < pct);
      smp_done  = (stray || m == 3) && ($urandom_range(99) < 40);
      if (meddle) begin
        cfg_we    = ($urandom_range(3) == 0);
        cfg_addr  = {3'($urandom_range(nl)), 2'($urandom_range(3))};
        cfg_wdata = $urandom;
        start     = ($urandom_range(7) == 0);
        nlayers   = 3'($urandom_range(NL - 1));
      end
      bt = (m == 1 || m == 2) ? (src_valid & src_ready) : ((m == 3) ? smp_done : 1'b0);
      g  = obs_geom();
      if (!have || m != cur.mode) begin
        if (have) segq.push_back(cur);
        cur = mk_seg(m, 1, int'(bt), g, int'(cur_layer));
        cur.last_ev = bt;
        have = 1'b1;
      end else begin
        cur.len++;
        cur.ev += int'(bt);
        cur.last_ev = bt;
        if (g !== cur.geom) cur.geom_stable = 1'b0;
        if (int'(cur_layer) != cur.layer) cur.layer_stable = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (have) segq.push_back(cur);
    src_valid = 1'b0; src_ready = 1'b0; smp_done = 1'b0; cfg_we = 1'b0; start = 1'b0;
    timed_out = (done !== 1'b1);
    done_busy = busy;
    done_cnt  = (done === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b0) extra_busy = 1'b1;
    end
  endtask

  task automatic score_sequence(input string name);
    int n;
    n = (segq.size() < expq.size()) ? segq.size() : expq.size();
    n_checks++;
    if (timed_out) begin
      n_fail++; $display("FAIL %s timeout: no done within %0d cycles", name, BUDGET);
    end
    n_checks++;
    if (first_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_t1: got %b want 1", name, first_busy);
    end
    n_checks++;
    if (segq.size() != expq.size()) begin
      n_fail++; $display("FAIL %s phase_count: got %0d want %0d", name, segq.size(), expq.size());
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (segq[i].mode != expq[i].mode) begin
        n_fail++;
        $display("FAIL %s phase%0d mode: got %0d want %0d", name, i, segq[i].mode, expq[i].mode);
        break;
      end
      if (expq[i].mode == 0) begin
        n_checks++;
        if (segq[i].len != expq[i].len) begin
          n_fail++;
          $display("FAIL %s phase%0d idle_len: got %0d want %0d", name, i, segq[i].len, expq[i].len);
        end
      end else begin
        n_checks++;
        if (segq[i].ev != expq[i].ev || !segq[i].last_ev) begin
          n_fail++;
          $display("FAIL %s phase%0d events: got %0d (ends_on_event=%0d) want %0d ending on event",
                   name, i, segq[i].ev, segq[i].last_ev, expq[i].ev);
        end
        n_checks++;
        if (!segq[i].geom_stable || segq[i].geom !== expq[i].geom) begin
          n_fail++;
          $display("FAIL %s phase%0d geometry: got %h stable=%0d want %h", name, i,
                   segq[i].geom, segq[i].geom_stable, expq[i].geom);
        end
        n_checks++;
        if (!segq[i].layer_stable || segq[i].layer != expq[i].layer) begin
          n_fail++;
          $display("FAIL %s phase%0d cur_layer: got %0d want %0d", name, i, segq[i].layer, expq[i].layer);
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || done_busy !== 1'b0 || extra_busy) begin
      n_fail++;
      $display("FAIL %s done: got %0d pulses busy_at_done=%b busy_after=%0d want 1 pulse, busy 0",
               name, done_cnt, done_busy, extra_busy);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_modes: got %b want 00000", {bwrite, wwrite, run, busy, done});
    end
    n_checks++;
    if (cur_layer !== '0 || obs_geom() !== '0) begin
      n_fail++; $display("FAIL reset_geom: got layer %0d geom %h want 0", cur_layer, obs_geom());
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b want 00000", {bwrite, wwrite, run, busy, done});
    end
  endtask

  task automatic test_forward_single();
    load_desc(0, 1'b0, 3, 99, 1);
    run_seq(0, 100, 1'b0, 1'b0);
    build_expect(0);
    score_sequence("fwd1");
    n_checks++;
    if (segq.size() < 4 || segq[1].len != 4 || segq[3].len != 100) begin
      n_fail++;
      $display("FAIL fwd1_lengths: got bias %0d wgt %0d want 4 100",
               (segq.size() > 1) ? segq[1].len : -1, (segq.size() > 3) ? segq[3].len : -1);
    end
  endtask

  task automatic test_backprop();
    load_desc(0, 1'b1, $urandom_range(15), 20, 2);
    run_seq(0, 100, 1'b0, 1'b0);
    build_expect(0);
    score_sequence("backprop");
    n_checks++;
    if (segq.size() < 2 || segq[0].len != 2 || segq[1].mode != 2) begin
      n_fail++; $display("FAIL backprop_first_wwrite: got %0d idle cycles want 2 then wwrite",
                         (segq.size() > 0) ? segq[0].len : -1);
    end
  endtask

  task automatic test_three_layers();
    int runs;
    for (int l = 0; l < 3; l++)
      load_desc(l, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(30), $urandom_range(3));
    run_seq(2, 100, 1'b0, 1'b0);
    build_expect(2);
    score_sequence("three_layers");
    runs = 0;
    foreach (segq[i]) if (segq[i].mode == 3) runs++;
    n_checks++;
    if (runs != 3) begin
      n_fail++; $display("FAIL three_layers_runs: got %0d run phases want 3", runs);
    end
  endtask

  task automatic test_random_gaps();
    int nl;
    for (int it = 0; it < 4; it++) begin
      nl = $urandom_range(3);
      for (int l = 0; l <= nl; l++)
        load_desc(l, 1'($urandom_range(1)), $urandom_range(15), $urandom_range(30), $urandom_range(3));
      run_seq(nl, 50, 1'b1, 1'b0);
      build_expect(nl);
      score_sequence($sformatf("gaps%0d", it));
    end
  endtask

  task automatic test_busy_meddle();
    for (int l = 0; l < 2; l++)
      load_desc(l, 1'b0, $urandom_range(15), $urandom_range(30), $urandom_range(3));
    run_seq(1, 70, 1'b0, 1'b1);
    build_expect(1);
    score_sequence("meddle");
    run_seq(1, 100, 1'b0, 1'b0);
    score_sequence("meddle_readback");
  endtask

  task automatic test_reset_mid_wgt();
    bit seen;
    for (int l = 0; l < 2; l++) load_desc(l, 1'b0, 5, 60, 1);
    start = 1'b1; nlayers = 3'd1;
    @(negedge clk);
    start = 1'b0; src_valid = 1'b1; src_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (wwrite === 1'b1) seen = 1'b1;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (!seen || wwrite !== 1'b1) begin
      n_fail++; $display("FAIL rst_reach_wgt: got wwrite %b want 1 before reset", wwrite);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bwrite, wwrite, run, busy, done} !== 5'b0 || cur_layer !== '0 || obs_geom() !== '0) begin
      n_fail++; $display("FAIL rst_mid_wgt: got modes %b layer %0d geom %h want all 0",
                         {bwrite, wwrite, run, busy, done}, cur_layer, obs_geom());
    end
    @(negedge clk);
    rst = 1'b0; src_valid = 1'b0; src_ready = 1'b0;
    @(negedge clk);
    for (int l = 0; l < NL; l++) for (int wi = 0; wi < 4; wi++) tbl[l][wi] = '0;
    run_seq(0, 100, 1'b0, 1'b0);
    build_expect(0);
    score_sequence("rst_table_zero");
    for (int l = 0; l < 2; l++) load_desc(l, 1'b0, 5, 60, 1);
    run_seq(1, 100, 1'b0, 1'b0);
    build_expect(1);
    score_sequence("rst_replay");
  endtask

  task automatic test_boundary();
    load_desc(0, 1'b0, 15, 16383, 4095);
    run_seq(0, 100, 1'b0, 1'b0);
    build_expect(0);
    score_sequence("max_counts");
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; nlayers = '0;
    src_valid = 1'b0; src_ready = 1'b0; smp_done = 1'b0;
    for (int l = 0; l < NL; l++) for (int wi = 0; wi < 4; wi++) tbl[l][wi] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_forward_single();
    test_backprop();
    test_three_layers();
    test_random_gaps();
    test_busy_meddle();
    test_reset_mid_wgt();
    test_boundary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
